// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, ctrl bit
// positions and the micro-step state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int unsigned CTRL_W = 16;

    localparam int unsigned C_HLT      = 0;
    localparam int unsigned C_MAR_IN   = 1;
    localparam int unsigned C_RAM_IN   = 2;
    localparam int unsigned C_RAM_OUT  = 3;
    localparam int unsigned C_IR_IN    = 4;
    localparam int unsigned C_IR_OUT   = 5;
    localparam int unsigned C_A_IN     = 6;
    localparam int unsigned C_A_OUT    = 7;
    localparam int unsigned C_ALU_OUT  = 8;
    localparam int unsigned C_ALU_SUB  = 9;
    localparam int unsigned C_FLAGS_IN = 10;
    localparam int unsigned C_B_IN     = 11;
    localparam int unsigned C_OUT_IN   = 12;
    localparam int unsigned C_PC_INC   = 13;
    localparam int unsigned C_PC_OUT   = 14;
    localparam int unsigned C_PC_LOAD  = 15;

    // Encoding doubles as the tstate output value (HALT reads as 0).
    typedef enum logic [2:0] {
        S_HALT = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word and a flag
// marking the final micro-step of the instruction.
module cpu_microcode_rom
    import cpu_pkg::*;
(
    input  logic [3:0]        opcode,
    input  state_t            step,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic [CTRL_W-1:0] ctrl,
    output logic              last_step
);

    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        case (step)
            S_T1: begin
                ctrl[C_PC_OUT] = 1'b1;
                ctrl[C_PC_INC] = 1'b1;
                ctrl[C_MAR_IN] = 1'b1;
            end
            S_T2: begin
                ctrl[C_RAM_OUT] = 1'b1;
                ctrl[C_IR_IN]   = 1'b1;
                ctrl[C_PC_INC]  = 1'b1;
                // NOP and the undefined opcodes have no execute phase.
                last_step = (opcode == OP_NOP) || (opcode >= 4'h9 && opcode <= 4'hD);
            end
            S_T3: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl[C_IR_OUT] = 1'b1;
                        ctrl[C_MAR_IN] = 1'b1;
                        last_step      = 1'b0;
                    end
                    OP_LDI: begin
                        ctrl[C_IR_OUT] = 1'b1;
                        ctrl[C_A_IN]   = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl[C_IR_OUT]  = 1'b1;
                        ctrl[C_PC_LOAD] = 1'b1;
                    end
                    OP_JC: begin
                        ctrl[C_IR_OUT]  = 1'b1;
                        ctrl[C_PC_LOAD] = carry_flag;
                    end
                    OP_JZ: begin
                        ctrl[C_IR_OUT]  = 1'b1;
                        ctrl[C_PC_LOAD] = zero_flag;
                    end
                    OP_OUT: begin
                        ctrl[C_A_OUT]  = 1'b1;
                        ctrl[C_OUT_IN] = 1'b1;
                    end
                    OP_HLT: ctrl[C_HLT] = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA: begin
                        ctrl[C_RAM_OUT] = 1'b1;
                        ctrl[C_A_IN]    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[C_RAM_OUT] = 1'b1;
                        ctrl[C_B_IN]    = 1'b1;
                        last_step       = 1'b0;
                    end
                    OP_STA: begin
                        ctrl[C_A_OUT]  = 1'b1;
                        ctrl[C_RAM_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                last_step = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl[C_ALU_OUT]  = 1'b1;
                    ctrl[C_A_IN]     = 1'b1;
                    ctrl[C_FLAGS_IN] = 1'b1;
                    ctrl[C_ALU_SUB]  = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Micro-step sequencer: holds the T-state, applies run/halt gating and
// drives the control word from the microcode ROM.
module cpu_control_sequencer
    import cpu_pkg::*;
(
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              run,
    input  logic [3:0]        ir_opcode,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic [CTRL_W-1:0] ctrl,
    output logic [2:0]        tstate,
    output logic              halted
);

    state_t            state;
    state_t            state_next;
    logic [CTRL_W-1:0] rom_ctrl;
    logic              rom_last;
    logic [CTRL_W-1:0] ctrl_int;

    cpu_microcode_rom u_rom (
        .opcode     (ir_opcode),
        .step       (state),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl       (rom_ctrl),
        .last_step  (rom_last)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_T1;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= (state_next == S_HALT);
        end
    end

    always_comb begin
        state_next = state;
        ctrl_int   = '0;
        if (state != S_HALT && run) begin
            ctrl_int = rom_ctrl;
            if (rom_ctrl[C_HLT]) begin
                state_next = S_HALT;
            end else if (rom_last) begin
                state_next = S_T1;
            end else begin
                case (state)
                    S_T1:    state_next = S_T2;
                    S_T2:    state_next = S_T3;
                    S_T3:    state_next = S_T4;
                    S_T4:    state_next = S_T5;
                    default: state_next = S_T1;
                endcase
            end
        end
    end

    // Reset blanks the control word asynchronously, not just at the next edge.
    assign ctrl   = rst_n ? ctrl_int : '0;
    assign tstate = state;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Scoreboard bench for cpu_control_sequencer: a driver pushes the expected
// per-cycle response from an instruction-level model; a monitor compares.
module tb_cpu_control_sequencer;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b1;
    logic [3:0]  ir_opcode = 4'h0;
    logic        carry_flag = 1'b0;
    logic        zero_flag = 1'b0;
    logic [15:0] ctrl;
    logic [2:0]  tstate;
    logic        halted;

    cpu_control_sequencer dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .run        (run),
        .ir_opcode  (ir_opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl       (ctrl),
        .tstate     (tstate),
        .halted     (halted)
    );

    always #5 clkin = ~clkin;

    typedef struct packed {
        logic [15:0] c;
        logic [2:0]  t;
        logic        h;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   driver_done = 0;

    // Instruction-level model state: step index within instruction, halt flag.
    int   mk = 0;
    bit   mhlt = 0;

    localparam logic [15:0] BUS_DRIVERS = 16'h41A8;

    // Whole-instruction control word sequence, straight from the opcode table.
    function automatic int build(input logic [3:0] op, input logic c, input logic z,
                                 output logic [15:0] w[5]);
        int n;
        w[0] = 16'h6002;
        w[1] = 16'h2018;
        w[2] = 16'h0000;
        w[3] = 16'h0000;
        w[4] = 16'h0000;
        n = 3;
        case (op)
            4'h1: begin w[2] = 16'h0022; w[3] = 16'h0048; n = 4; end
            4'h2: begin w[2] = 16'h0022; w[3] = 16'h0808; w[4] = 16'h0540; n = 5; end
            4'h3: begin w[2] = 16'h0022; w[3] = 16'h0808; w[4] = 16'h0740; n = 5; end
            4'h4: begin w[2] = 16'h0022; w[3] = 16'h0084; n = 4; end
            4'h5: w[2] = 16'h0060;
            4'h6: w[2] = 16'h8020;
            4'h7: w[2] = c ? 16'h8020 : 16'h0020;
            4'h8: w[2] = z ? 16'h8020 : 16'h0020;
            4'hE: w[2] = 16'h1080;
            4'hF: w[2] = 16'h0001;
            default: n = 2;
        endcase
        return n;
    endfunction

    task automatic cyc(input logic [3:0] op, input logic c, input logic z,
                       input logic r, input logic rn);
        logic [15:0] w[5];
        int n;
        exp_t e;
        @(posedge clkin);
        #1;
        ir_opcode  = op;
        carry_flag = c;
        zero_flag  = z;
        run        = r;
        rst_n      = rn;
        if (!rn) begin
            mk   = 0;
            mhlt = 0;
        end
        n = build(op, c, z, w);
        if (mhlt) begin
            e.c = 16'h0000; e.t = 3'd0; e.h = 1'b1;
        end else begin
            e.c = (rn && r) ? w[mk] : 16'h0000;
            e.t = 3'(mk + 1);
            e.h = 1'b0;
        end
        q.push_back(e);
        if (rn && r && !mhlt) begin
            mk++;
            if (mk == n) begin
                mk = 0;
                if (op == 4'hF) mhlt = 1;
            end
        end
    endtask

    task automatic instr(input logic [3:0] op, input logic c, input logic z);
        logic [15:0] w[5];
        int n;
        n = build(op, c, z, w);
        for (int i = 0; i < n; i++) cyc(op, c, z, 1'b1, 1'b1);
    endtask

    // Monitor: every cycle the DUT presents a state; compare at the falling edge.
    always @(negedge clkin) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (ctrl !== e.c) begin
                n_fail++;
                $display("FAIL ctrl t=%0t got=%h exp=%h", $time, ctrl, e.c);
            end
            n_checks++;
            if (tstate !== e.t) begin
                n_fail++;
                $display("FAIL tstate t=%0t got=%0d exp=%0d", $time, tstate, e.t);
            end
            n_checks++;
            if (halted !== e.h) begin
                n_fail++;
                $display("FAIL halted t=%0t got=%b exp=%b", $time, halted, e.h);
            end
            n_checks++;
            if ($countones(ctrl & BUS_DRIVERS) > 1) begin
                n_fail++;
                $display("FAIL bus_drivers t=%0t got=%h exp=at most one driver", $time, ctrl);
            end
        end
    end

    initial begin
        logic [3:0] op;
        logic       c, z, r, rn;

        // Reset, then ADD followed by the next fetch.
        repeat (3) cyc(4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
        instr(4'h2, 1'b0, 1'b0);
        instr(4'h7, 1'b1, 1'b0);
        instr(4'h7, 1'b0, 1'b0);
        instr(4'h8, 1'b0, 1'b1);
        instr(4'h8, 1'b0, 1'b0);
        instr(4'hB, 1'b0, 1'b0);
        instr(4'h0, 1'b0, 1'b0);

        // LDA with a 3-cycle run stall in T3.
        cyc(4'h1, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(4'h1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) cyc(4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'h1, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(4'h1, 1'b0, 1'b0, 1'b1, 1'b1);

        instr(4'h4, 1'b0, 1'b0);
        instr(4'h5, 1'b0, 1'b0);
        instr(4'h6, 1'b0, 1'b0);
        instr(4'hE, 1'b0, 1'b0);
        instr(4'h3, 1'b0, 1'b0);

        // ADD aborted by reset in T4, then a clean restart.
        repeat (3) cyc(4'h2, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
        instr(4'h2, 1'b0, 1'b0);

        // HLT, stay halted for 20 cycles regardless of inputs, then reset.
        instr(4'hF, 1'b0, 1'b0);
        repeat (20) cyc(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        cyc(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        instr(4'h2, 1'b0, 1'b0);

        // Random run: new opcode only at instruction boundaries.
        op = 4'h0;
        for (int i = 0; i < 1000; i++) begin
            if (mk == 0 && !mhlt) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h2;
            end
            c  = 1'($urandom);
            z  = 1'($urandom);
            r  = ($urandom_range(0, 4) != 0);
            rn = !(mhlt && $urandom_range(0, 7) == 0) && ($urandom_range(0, 199) != 0);
            cyc(op, c, z, r, rn);
        end

        @(posedge clkin);
        @(posedge clkin);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
        end
        driver_done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        if (!driver_done) begin
            $display("FAIL timeout got=running exp=finished");
            $fatal(1, "timeout");
        end
    end

endmodule
